// File: rtl/pipe_pkg.sv
// Shared control-path pipeline types: the execute-stage control bundle,
// its bubble encoding, and the skid-register slot state used for debug/assertions.
package pipe_pkg;

   typedef struct packed {
      logic [2:0] RegWrite;
      logic [1:0] ResultSrc;
      logic [1:0] MemWrite;
      logic       Jump;
      logic       Branch;
      logic [2:0] ALUControl;
      logic       ALUSrc;
      logic [2:0] funct3;
   } ctrl_e_t;

   localparam int      CTRL_W      = $bits(ctrl_e_t);
   localparam ctrl_e_t CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} slot_e;

   // Occupancy is carried by the two valid flags; this names the combination.
   function automatic slot_e slot_of(input logic main_v, input logic skid_v);
      if (!main_v)     return EMPTY;
      else if (!skid_v) return ONE;
      else              return TWO;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   localparam logic [CNT_WIDTH-1:0] STEP = 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + STEP;
   end

endmodule

// File: rtl/pipe_ctrl_skid_reg.sv
// Control-path pipeline register with a 2-entry skid buffer, synchronous flush
// and bubble output; in_ready comes from registered state only.
module pipe_ctrl_skid_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] BUBBLE    = '0,
   parameter int               CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   logic             main_valid, skid_valid;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             main_valid_d, skid_valid_d;
   logic             ld_main_in, ld_main_skid, ld_skid;
   logic             in_fire, out_fire;
   slot_e            state;

   assign in_ready  = !skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_valid ? main_q : BUBBLE;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign state     = slot_of(main_valid, skid_valid);

   always_comb begin
      main_valid_d = main_valid;
      skid_valid_d = skid_valid;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      // Flush wins over everything; a same-cycle in_fire is swallowed.
      if (flush_i) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         case (state)
            EMPTY: if (in_fire) begin
               ld_main_in   = 1'b1;
               main_valid_d = 1'b1;
            end
            ONE: begin
               if (in_fire && out_fire)
                  ld_main_in = 1'b1;
               else if (out_fire)
                  main_valid_d = 1'b0;
               else if (in_fire) begin
                  ld_skid      = 1'b1;
                  skid_valid_d = 1'b1;
               end
            end
            TWO: if (out_fire) begin
               ld_main_skid = 1'b1;
               skid_valid_d = 1'b0;
            end
            default: begin
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= BUBBLE;
         skid_q     <= BUBBLE;
      end else begin
         main_valid <= main_valid_d;
         skid_valid <= skid_valid_d;
         if (ld_main_in)
            main_q <= in_data;
         else if (ld_main_skid)
            main_q <= skid_q;
         if (ld_skid)
            skid_q <= in_data;
      end
   end

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (main_valid & !out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_i),
      .count (flush_cnt)
   );

   a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst)
      !(skid_valid && !main_valid));

endmodule

// File: tb/tb_pipe_ctrl_skid_reg.sv
// Directed bench: stimulus pushes expected deliveries into a scoreboard queue,
// a negedge monitor pops and compares on every out_valid & out_ready.
module tb_pipe_ctrl_skid_reg;

   localparam int W  = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   int compared = 0;
   int errors   = 0;
   logic [W-1:0] sb[$];

   always #5 clk = ~clk;

   pipe_ctrl_skid_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (flush_i),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every handshake must match the next expected payload.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            compared++;
            errors++;
            $display("FAIL sb_unexpected: got 0x%08h expected no delivery at %0t", out_data, $time);
         end else begin
            chk("sb_data", out_data, sb.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; flush_i = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5A5A5; out_ready = 1'b1;
      repeat (3) step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  out_data, 32'h0);
      chk("rst_in_ready",  32'(in_ready), 32'd1);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      in_valid = 1'b0;
      rst = 1'b0;
      step();

      // Stream 1..4 with out_ready high
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_data = 32'(i); sb.push_back(32'(i));
         step();
         chk("stream_data", out_data, 32'(i));
         chk("stream_in_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      step();
      chk("stream_empty", 32'(out_valid), 32'd0);
      chk("stream_stall", 32'(stall_cnt), 32'd0);

      // Backpressure: 0x11 in main, 0x22 into skid, 0x33 held off
      in_valid = 1'b1; in_data = 32'h11; sb.push_back(32'h11);
      step();
      out_ready = 1'b0; in_data = 32'h22; sb.push_back(32'h22);
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold1", out_data, 32'h11);
      chk("bp_stall1", 32'(stall_cnt), 32'd1);
      in_data = 32'h33;
      step();
      chk("bp_hold2", out_data, 32'h11);
      chk("bp_stall2", 32'(stall_cnt), 32'd2);
      step();
      chk("bp_hold3", out_data, 32'h11);
      chk("bp_stall3", 32'(stall_cnt), 32'd3);
      chk("bp_in_ready3", 32'(in_ready), 32'd0);
      sb.push_back(32'h33);
      out_ready = 1'b1;
      step();
      chk("bp_drain1", out_data, 32'h22);
      chk("bp_in_ready4", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_drain2", out_data, 32'h33);
      step();
      chk("bp_empty", 32'(out_valid), 32'd0);
      chk("bp_stall_final", 32'(stall_cnt), 32'd3);

      // Flush while TWO: neither entry may be delivered
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
      step();
      in_data = 32'h22;
      step();
      chk("fl_full", 32'(in_ready), 32'd0);
      in_valid = 1'b0; flush_i = 1'b1;
      step();
      flush_i = 1'b0; out_ready = 1'b1;
      chk("fl_out_valid", 32'(out_valid), 32'd0);
      chk("fl_out_data", out_data, 32'h0);
      chk("fl_in_ready", 32'(in_ready), 32'd1);
      chk("fl_cnt1", 32'(flush_cnt), 32'd1);
      chk("fl_stall", 32'(stall_cnt), 32'd5);

      // Flush with simultaneous in_fire: 0x44 discarded, 0x55 follows normally
      flush_i = 1'b1; in_valid = 1'b1; in_data = 32'h44;
      step();
      chk("fl2_out_valid", 32'(out_valid), 32'd0);
      flush_i = 1'b0; in_data = 32'h55; sb.push_back(32'h55);
      step();
      chk("fl2_lat_valid", 32'(out_valid), 32'd1);
      chk("fl2_lat_data", out_data, 32'h55);
      in_valid = 1'b0;
      step();
      chk("fl2_cnt", 32'(flush_cnt), 32'd2);

      // Saturation: stall counter sticks at 15
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h66; sb.push_back(32'h66);
      step();
      in_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("sat_stall", 32'(stall_cnt), (5 + k > 15) ? 32'd15 : 32'(5 + k));
      end
      chk("sat_hold_data", out_data, 32'h66);
      out_ready = 1'b1;
      step();
      chk("sat_drained", 32'(out_valid), 32'd0);

      // Async reset with an entry held drops it immediately
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_stall", 32'(stall_cnt), 32'd0);
      step();
      rst = 1'b0; out_ready = 1'b1;
      repeat (2) step();
      chk("arst_no_deliver", 32'(out_valid), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_skid_reg.md
Name: pipe_ctrl_skid_reg

Overview:
- Parametrised control-path pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble insertion.
- Replaces the fixed decode→execute control registers. Any stage boundary (D→E, E→M, M→W) instantiates it with a packed control payload.
- Downstream backpressure is absorbed without a combinational ready path. Flushed or empty slots present a bubble payload, so RegWrite, MemWrite, Jump and Branch read as zero.
- Saturating stall and flush counters feed the perf/debug readout.

Parameters:
- WIDTH, 32: payload width in bits (packed control bundle).
- BUBBLE, all-zeros WIDTH-bit value: payload driven on out_data when out_valid=0.
- CNT_WIDTH, 16: width of each saturating statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous kill of all held entries (branch mispredict or trap).
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  block can accept; driven from registered state only.
- in_data  in  WIDTH  upstream control payload.
- out_valid  out  1  main entry is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  main payload, or BUBBLE when not valid.
- stall_cnt  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0.
- flush_cnt  out  CNT_WIDTH  cycles with flush_i=1.

Behaviour:
- Storage is main_q and skid_q, each with a valid flag. State is derived from the flags:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - TWO: both valid.
  - Skid valid with main invalid is illegal; assert never.
- Handshake fires:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Port equations:
  - in_ready = !skid_valid.
  - out_valid = main_valid.
  - out_data = main_valid ? main_q : BUBBLE.
- Transitions when flush_i=0:
  - EMPTY: in_fire → main<=in_data, go to ONE. Otherwise stay.
  - ONE, in_fire & out_fire: main<=in_data, stay ONE.
  - ONE, out_fire only: go to EMPTY.
  - ONE, in_fire only: skid<=in_data, go to TWO.
  - ONE, neither: hold.
  - TWO: in_ready=0. out_fire → main<=skid_q, skid invalid, go to ONE. Otherwise hold.
- Flush:
  - flush_i has priority over every transition. Next state is EMPTY; both valid flags clear.
  - Data registers need not change.
  - An in_fire in the flush cycle is accepted and discarded.
  - An out_fire in the flush cycle counts as delivered; downstream owns its own flush.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid.
  - Sustained throughput is 1 per cycle with out_ready held high.
  - out_data stays stable while out_valid=1 and out_ready=0.
- Counters:
  - stall_cnt +1 on each cycle with out_valid & !out_ready.
  - flush_cnt +1 on each cycle with flush_i=1.
  - Both saturate at all-ones and never wrap.
- Reset (async assert, release synchronised externally):
  - main_valid=0, skid_valid=0, both counters=0.
  - Hence out_valid=0, out_data=BUBBLE, in_ready=1, including while rst is held.
  - Reset mid-transfer drops both entries with no partial update.
- No X propagation: data registers reset to BUBBLE.

Decomposition:
- Shared package pipe_pkg holds:
  - ctrl_e_t: packed struct of RegWrite[2:0], ResultSrc[1:0], MemWrite[1:0], Jump, Branch, ALUControl[2:0], ALUSrc, funct3[2:0]. Width is $bits(ctrl_e_t).
  - CTRL_BUBBLE constant (all zeros).
  - A slot-state enum {EMPTY, ONE, TWO} for assertions and debug.
- One natural sub-module, sat_counter #(CNT_WIDTH) (inc, count, async rst), instantiated twice.

Test Plan:
- Reset: assert rst with in_valid=1 and in_data=0xA5A5A5A5 → out_valid=0, out_data=0x00000000, in_ready=1, stall_cnt=0.
- Stream: out_ready=1, in_valid=1 with payloads 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 one cycle later each, in_ready stays 1.
- Backpressure: load 0x11, drop out_ready, offer 0x22 → skid fills and in_ready=0. 0x33 is held off; out_data stays 0x11 with stall_cnt counting 1,2,3. Raise out_ready → outputs 0x11, 0x22, then 0x33, no loss or duplication.
- Flush in TWO: with 0x11 and 0x22 held, pulse flush_i for one cycle → next cycle out_valid=0, out_data=BUBBLE, in_ready=1, flush_cnt=1. Neither entry is ever delivered.
- Simultaneous flush and in_fire: in_valid=1 with 0x44 in the flush cycle → 0x44 never appears; the next payload 0x55 arrives with 1-cycle latency.
- Saturation (CNT_WIDTH=4): hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays 15.
